// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between mem_port_arbiter, its two requesters and the memory macro.
// The slave modport is the arbiter's view; master is the view of the core and memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store with
// round-robin arbitration, one fixed-latency transaction outstanding at a time.
//
// state | meaning
// IDLE  | no transaction outstanding; grant decided combinationally this cycle
// WAIT  | transaction outstanding; down-counter runs to terminal count 0
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  owner_d;
    logic                  store;
    logic                  last_d;
    logic                  grant_ok;
    logic                  win_if;
    logic                  win_d;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;

    // Grants are gated by rst_n so the bus is quiet while reset is asserted.
    assign grant_ok  = rst_n && (state == IDLE);
    assign win_d     = grant_ok && bus.d_req && (!bus.if_req || !last_d);
    assign win_if    = grant_ok && bus.if_req && !win_d;
    assign win_addr  = win_d ? bus.d_addr : bus.if_addr;
    assign win_wdata = win_d ? bus.d_wdata : '0;

    assign bus.if_gnt    = win_if;
    assign bus.d_gnt     = win_d;
    assign bus.mem_en    = win_if || win_d;
    assign bus.mem_we    = win_d && bus.d_we;
    assign bus.mem_addr  = (win_if || win_d) ? win_addr : '0;
    assign bus.mem_wdata = win_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            owner_d       <= 1'b0;
            store         <= 1'b0;
            last_d        <= 1'b1;
            bus.if_rvalid <= 1'b0;
            bus.d_rvalid  <= 1'b0;
            bus.if_rdata  <= '0;
            bus.d_rdata   <= '0;
        end else begin
            bus.if_rvalid <= 1'b0;
            bus.d_rvalid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_if || win_d) begin
                        owner_d <= win_d;
                        store   <= win_d && bus.d_we;
                        last_d  <= win_d;
                        cnt     <= CNT_W'(MEM_LATENCY - 1);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= IDLE;
                        if (owner_d) begin
                            bus.d_rvalid <= 1'b1;
                            if (!store) bus.d_rdata <= bus.mem_rdata;
                        end else begin
                            bus.if_rvalid <= 1'b1;
                            bus.if_rdata  <= bus.mem_rdata;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: two instances (latency 2 and 1) share one
// stimulus scheme and are compared against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int NCYC = 3000;

    logic clk;
    logic rst_n;

    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_a ();
    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_b ();

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(2)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-instance stimulus (index 0 -> latency 2, index 1 -> latency 1)
    logic        if_req_v  [2];
    logic [31:0] if_addr_v [2];
    logic        d_req_v   [2];
    logic        d_we_v    [2];
    logic [31:0] d_addr_v  [2];
    logic [31:0] d_wdata_v [2];
    logic [31:0] mem_rd    [2];

    logic        if_gnt_o [2], if_rvalid_o [2], d_gnt_o [2], d_rvalid_o [2];
    logic        mem_en_o [2], mem_we_o [2];
    logic [31:0] if_rdata_o [2], d_rdata_o [2], mem_addr_o [2], mem_wdata_o [2];

    assign bus_a.if_req = if_req_v[0];   assign bus_b.if_req = if_req_v[1];
    assign bus_a.if_addr = if_addr_v[0]; assign bus_b.if_addr = if_addr_v[1];
    assign bus_a.d_req = d_req_v[0];     assign bus_b.d_req = d_req_v[1];
    assign bus_a.d_we = d_we_v[0];       assign bus_b.d_we = d_we_v[1];
    assign bus_a.d_addr = d_addr_v[0];   assign bus_b.d_addr = d_addr_v[1];
    assign bus_a.d_wdata = d_wdata_v[0]; assign bus_b.d_wdata = d_wdata_v[1];
    assign bus_a.mem_rdata = mem_rd[0];  assign bus_b.mem_rdata = mem_rd[1];

    assign if_gnt_o[0] = bus_a.if_gnt;       assign if_gnt_o[1] = bus_b.if_gnt;
    assign if_rvalid_o[0] = bus_a.if_rvalid; assign if_rvalid_o[1] = bus_b.if_rvalid;
    assign if_rdata_o[0] = bus_a.if_rdata;   assign if_rdata_o[1] = bus_b.if_rdata;
    assign d_gnt_o[0] = bus_a.d_gnt;         assign d_gnt_o[1] = bus_b.d_gnt;
    assign d_rvalid_o[0] = bus_a.d_rvalid;   assign d_rvalid_o[1] = bus_b.d_rvalid;
    assign d_rdata_o[0] = bus_a.d_rdata;     assign d_rdata_o[1] = bus_b.d_rdata;
    assign mem_en_o[0] = bus_a.mem_en;       assign mem_en_o[1] = bus_b.mem_en;
    assign mem_we_o[0] = bus_a.mem_we;       assign mem_we_o[1] = bus_b.mem_we;
    assign mem_addr_o[0] = bus_a.mem_addr;   assign mem_addr_o[1] = bus_b.mem_addr;
    assign mem_wdata_o[0] = bus_a.mem_wdata; assign mem_wdata_o[1] = bus_b.mem_wdata;

    function automatic int lat(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic logic [31:0] init_val(input int k, input int idx);
        return 32'hC0DE_0000 ^ (32'(idx) * 32'h0101_0101) ^ 32'(k << 20);
    endfunction

    // Memory macro: 16 words aliased on addr[5:2]; unread cycles return noise.
    bit [31:0] mem_arr [2][16];
    bit [15:0] wr_mask [2];
    bit [31:0] pipe    [2][2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_en_o[k] && mem_we_o[k]) begin
                mem_arr[k][mem_addr_o[k][5:2]] <= mem_wdata_o[k];
                wr_mask[k][mem_addr_o[k][5:2]] <= 1'b1;
            end
            if (mem_en_o[k] && !mem_we_o[k])
                pipe[k][0] <= wr_mask[k][mem_addr_o[k][5:2]] ? mem_arr[k][mem_addr_o[k][5:2]]
                                                             : init_val(k, int'(mem_addr_o[k][5:2]));
            else
                pipe[k][0] <= $urandom;
            pipe[k][1] <= pipe[k][0];
        end
    end

    assign mem_rd[0] = pipe[0][1];
    assign mem_rd[1] = pipe[1][0];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: transaction view (free-at cycle, one pending response)
    logic [31:0] exp_mem    [2][16];
    int          next_free  [2];
    int          resp_cyc   [2];
    bit          resp_d     [2];
    bit          resp_load  [2];
    logic [31:0] resp_data  [2];
    bit          last_d     [2];
    logic [31:0] exp_if_rd  [2];
    logic [31:0] exp_d_rd   [2];
    bit          if_pend    [2];
    bit          d_pend     [2];
    bit          prev_gnt;
    int          cyc;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            next_free[k] = 0;
            resp_cyc[k]  = -1;
            last_d[k]    = 1'b1;
            exp_if_rd[k] = '0;
            exp_d_rd[k]  = '0;
        end
    endtask

    task automatic check_reset_outputs();
        for (int k = 0; k < 2; k++) begin
            chk_eq($sformatf("L%0d rst if_gnt", lat(k)), if_gnt_o[k], 0);
            chk_eq($sformatf("L%0d rst d_gnt", lat(k)), d_gnt_o[k], 0);
            chk_eq($sformatf("L%0d rst mem_en", lat(k)), mem_en_o[k], 0);
            chk_eq($sformatf("L%0d rst mem_we", lat(k)), mem_we_o[k], 0);
            chk_eq($sformatf("L%0d rst mem_addr", lat(k)), mem_addr_o[k], 0);
            chk_eq($sformatf("L%0d rst mem_wdata", lat(k)), mem_wdata_o[k], 0);
            chk_eq($sformatf("L%0d rst if_rvalid", lat(k)), if_rvalid_o[k], 0);
            chk_eq($sformatf("L%0d rst d_rvalid", lat(k)), d_rvalid_o[k], 0);
            chk_eq($sformatf("L%0d rst if_rdata", lat(k)), if_rdata_o[k], 0);
            chk_eq($sformatf("L%0d rst d_rdata", lat(k)), d_rdata_o[k], 0);
        end
    endtask

    task automatic drive_inputs(input int k, input bit force_both);
        if (!if_pend[k] && (force_both || $urandom_range(0, 9) < 5)) begin
            if_pend[k]   = 1'b1;
            if_addr_v[k] = $urandom;
        end
        if (!d_pend[k] && (force_both || $urandom_range(0, 9) < 5)) begin
            d_pend[k]    = 1'b1;
            d_we_v[k]    = force_both ? 1'b0 : 1'($urandom_range(0, 1));
            d_addr_v[k]  = $urandom;
            d_wdata_v[k] = $urandom;
        end
        if_req_v[k] = if_pend[k];
        d_req_v[k]  = d_pend[k];
    endtask

    task automatic model_check(input int k);
        bit          w_if, w_d, e_ifv, e_dv;
        logic [31:0] e_addr, e_wdata;
        int          idx;
        e_ifv = (resp_cyc[k] == cyc) && !resp_d[k];
        e_dv  = (resp_cyc[k] == cyc) && resp_d[k];
        if (e_ifv) exp_if_rd[k] = resp_data[k];
        if (e_dv && resp_load[k]) exp_d_rd[k] = resp_data[k];
        w_if = 1'b0;
        w_d  = 1'b0;
        if (cyc >= next_free[k]) begin
            if (if_req_v[k] && d_req_v[k]) begin
                w_if = last_d[k];
                w_d  = !last_d[k];
            end else begin
                w_if = if_req_v[k];
                w_d  = d_req_v[k];
            end
        end
        e_addr  = w_d ? d_addr_v[k] : (w_if ? if_addr_v[k] : 32'h0);
        e_wdata = w_d ? d_wdata_v[k] : 32'h0;
        chk_eq($sformatf("L%0d if_gnt", lat(k)), if_gnt_o[k], w_if);
        chk_eq($sformatf("L%0d d_gnt", lat(k)), d_gnt_o[k], w_d);
        chk_eq($sformatf("L%0d mem_en", lat(k)), mem_en_o[k], w_if || w_d);
        chk_eq($sformatf("L%0d mem_we", lat(k)), mem_we_o[k], w_d && d_we_v[k]);
        chk_eq($sformatf("L%0d mem_addr", lat(k)), mem_addr_o[k], e_addr);
        chk_eq($sformatf("L%0d mem_wdata", lat(k)), mem_wdata_o[k], e_wdata);
        chk_eq($sformatf("L%0d if_rvalid", lat(k)), if_rvalid_o[k], e_ifv);
        chk_eq($sformatf("L%0d d_rvalid", lat(k)), d_rvalid_o[k], e_dv);
        chk_eq($sformatf("L%0d if_rdata", lat(k)), if_rdata_o[k], exp_if_rd[k]);
        chk_eq($sformatf("L%0d d_rdata", lat(k)), d_rdata_o[k], exp_d_rd[k]);
        if (w_if || w_d) begin
            idx          = w_d ? int'(d_addr_v[k][5:2]) : int'(if_addr_v[k][5:2]);
            next_free[k] = cyc + lat(k) + 1;
            resp_cyc[k]  = cyc + lat(k) + 1;
            resp_d[k]    = w_d;
            resp_load[k] = w_if || !d_we_v[k];
            resp_data[k] = exp_mem[k][idx];
            if (w_d && d_we_v[k]) exp_mem[k][idx] = d_wdata_v[k];
            last_d[k] = w_d;
            if (w_if) if_pend[k] = 1'b0;
            if (w_d) d_pend[k] = 1'b0;
            if (k == 0) prev_gnt = 1'b1;
        end
    endtask

    initial begin
        int  force_until;
        bit  gnt_rst_done;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) exp_mem[k][i] = init_val(k, i);
            if_pend[k]   = 1'b1;
            d_pend[k]    = 1'b1;
            if_req_v[k]  = 1'b1;
            if_addr_v[k] = 32'h10;
            d_req_v[k]   = 1'b1;
            d_we_v[k]    = 1'b0;
            d_addr_v[k]  = 32'h40;
            d_wdata_v[k] = 32'h0;
        end
        model_reset();
        cyc          = 0;
        force_until  = 12;
        gnt_rst_done = 1'b0;
        prev_gnt     = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            check_reset_outputs();
        end
        for (int n = 0; n < NCYC; n++) begin
            @(negedge clk);
            if ((cyc > 30 && !gnt_rst_done && prev_gnt) || $urandom_range(0, 299) == 0) begin
                if (cyc > 30) gnt_rst_done = 1'b1;
                rst_n = 1'b0;
                #1;
                check_reset_outputs();
                model_reset();
                force_until = cyc + 7;
                prev_gnt    = 1'b0;
            end else begin
                rst_n    = 1'b1;
                prev_gnt = 1'b0;
                for (int k = 0; k < 2; k++) drive_inputs(k, cyc < force_until);
                #1;
                for (int k = 0; k < 2; k++) model_check(k);
            end
            cyc++;
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between two requesters: the instruction-fetch path (read-only) and the load/store data path (read/write).
- Sits between the multicycle core (PC/IR/DMem datapath) and the memory macro.
- Uses a per-requester req/gnt/rvalid handshake, 1-bit round-robin arbitration and a fixed-latency memory pipeline.
- Runs one transaction at a time.

Parameters:
- ADDR_WIDTH, 32, address width of both requesters and the memory.
- DATA_WIDTH, 32, data width.
- MEM_LATENCY, 2, cycles from the mem_en cycle to valid mem_rdata; legal range ≥1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, level
- if_addr  in  ADDR_WIDTH  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_WIDTH  fetched word, held until next fetch response
- d_req  in  1  data request, level
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  one-cycle pulse: load data valid, or store complete
- d_rdata  out  DATA_WIDTH  load word, held until next load response
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after mem_en

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0, last_owner=DATA.
  - if_rvalid=d_rvalid=0, if_rdata=d_rdata=0.
  - gnt outputs and mem_* outputs are 0.
  - Any in-flight transaction is discarded and produces no rvalid.
- States:
  - IDLE: no transaction outstanding.
  - WAIT: transaction outstanding, down-counter running.
- IDLE arbitration (combinational, same cycle):
  - If exactly one req is high, that requester wins.
  - If both are high, the requester ≠ last_owner wins. Because last_owner resets to DATA, fetch wins first after reset.
  - In the winning cycle T: the winner's gnt=1, mem_en=1, mem_addr = winner's addr.
  - For a data winner: mem_we=d_we, mem_wdata=d_wdata. For a fetch winner: mem_we=0, mem_wdata=0.
  - Registered at the edge ending T: owner, store flag (d_we for data, 0 for fetch), last_owner=winner, counter=MEM_LATENCY-1, state→WAIT.
- Outside a grant cycle: mem_en=mem_we=0, mem_addr=mem_wdata=0, both gnt=0.
- WAIT:
  - While counter≠0, decrement.
  - When counter==0 (cycle T+MEM_LATENCY):
    - Load: capture mem_rdata into the owner's rdata register.
    - Store: rdata registers unchanged.
    - Set the owner's rvalid for the next cycle; state→IDLE.
- Response timing:
  - Owner's rvalid=1 for exactly cycle T+MEM_LATENCY+1; the other requester's rvalid stays 0.
  - State is IDLE in that cycle, so a new grant may occur in the same cycle as rvalid.
- Handshake rules:
  - A requester holds req, addr, we and wdata stable until gnt.
  - Every IDLE cycle with req=1 is a new request; a requester deasserts req the cycle after gnt unless it issues another.
  - gnt never asserts in WAIT.
  - Requests arriving during WAIT wait until IDLE.
- Throughput: one transaction per MEM_LATENCY+1 cycles.
- Both requesters continuously requesting → strict alternation.
- rdata registers change only on a load/fetch response for that requester.

Test Plan:
- MEM_LATENCY=2, if_req with if_addr=0x10 at cycle 0, memory returns 0xDEADBEEF at cycle 2 → cycle 0: if_gnt=1, mem_en=1, mem_addr=0x10, mem_we=0; cycle 3: if_rvalid=1, if_rdata=0xDEADBEEF; d_rvalid=0 throughout.
- if_req and d_req (load, 0x40) both high at cycle 0 after reset → if_gnt at cycle 0; d_gnt at cycle 3 with mem_addr=0x40 (same cycle as if_rvalid); d_rvalid at cycle 6.
- Store: d_req, d_we=1, d_addr=0x20, d_wdata=0x1234 → cycle 0: mem_en=1, mem_we=1, mem_addr=0x20, mem_wdata=0x1234; cycle 3: d_rvalid=1; d_rdata keeps its prior value.
- Both reqs held high for 12 cycles → grants at cycles 0, 3, 6, 9 in the order I, D, I, D; no back-to-back grants; mem_en high only on those cycles.
- Fetch granted at cycle 0, rst_n pulsed low at cycle 1 → asynchronously all outputs 0; no if_rvalid at cycle 3; after release with both reqs high, fetch is granted first.
- MEM_LATENCY=1 instance: d_req load at cycle 0, mem_rdata=0xCAFE0001 at cycle 1 → d_rvalid at cycle 2 with d_rdata=0xCAFE0001; next grant possible at cycle 2.
